dcache_direct: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the execute/memory pipeline stage and memoryunit.
- Read hits return sign/zero-extended load data combinationally.
- Read misses stall the pipeline while a full word is fetched from memoryunit.
- Stores pass straight through to memoryunit and invalidate any matching line.

---
 rtl/dcache_direct.sv | 109 ++++++++++
 tb/tb_dcache_direct.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped, write-through, no-write-allocate data cache.
// Loads hit combinationally; misses stall while one word is fetched from memory.
module dcache_direct #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int LINES = 8,
   parameter int MEM_LATENCY = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     readEnable_i,
   input  logic                     writeEnable_i,
   input  logic [ADDRESS_WIDTH-1:0] address_i,
   input  logic [DATA_WIDTH-1:0]    writeData_i,
   input  logic [2:0]               dataMemControl_i,
   output logic [DATA_WIDTH-1:0]    readData_o,
   output logic                     stall_o,
   output logic [ADDRESS_WIDTH-1:0] mem_address_o,
   output logic [DATA_WIDTH-1:0]    mem_writeData_o,
   output logic [2:0]               mem_dataMemControl_o,
   output logic                     mem_writeEnable_o,
   input  logic [DATA_WIDTH-1:0]    mem_readData_i,
   output logic [31:0]              hitCount_o,
   output logic [31:0]              missCount_o
);
   localparam int IW = $clog2(LINES);
   localparam int TW = ADDRESS_WIDTH - IW - 2;
   localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] FILL = 1'b1;

   logic [0:0]               state;
   logic [LINES-1:0]         valid;
   logic [TW-1:0]            tags [LINES];
   logic [DATA_WIDTH-1:0]    words [LINES];
   logic [ADDRESS_WIDTH-3:0] fill_word;
   logic [CW-1:0]            cnt;
   logic [IW-1:0]            idx;
   logic [IW-1:0]            fill_idx;
   logic [TW-1:0]            tag;
   logic                     match;
   logic                     load;
   logic                     hit;
   logic [DATA_WIDTH-1:0]    word;
   logic [7:0]               b;
   logic [15:0]              h;
   logic [DATA_WIDTH-1:0]    ld;

   assign idx      = address_i[IW+1:2];
   assign tag      = address_i[ADDRESS_WIDTH-1:IW+2];
   assign fill_idx = fill_word[IW-1:0];
   assign match    = valid[idx] && tags[idx] == tag;
   assign load     = state == IDLE && readEnable_i && !writeEnable_i;
   assign hit      = load && match;
   assign word     = words[idx];
   assign b        = word[{address_i[1:0], 3'b000} +: 8];
   assign h        = address_i[1] ? word[31:16] : word[15:0];

   // unused funct3 codes fall through to a full-word load
   always_comb begin
      ld = dataMemControl_i == 3'b000 ? {{(DATA_WIDTH-8){b[7]}}, b} :
           dataMemControl_i == 3'b100 ? {{(DATA_WIDTH-8){1'b0}}, b} :
           dataMemControl_i == 3'b001 ? {{(DATA_WIDTH-16){h[15]}}, h} :
           dataMemControl_i == 3'b101 ? {{(DATA_WIDTH-16){1'b0}}, h} : word;
      readData_o           = hit ? ld : '0;
      stall_o              = state == FILL || (load && !match);
      mem_address_o        = state == FILL ? {fill_word, 2'b00} : address_i;
      mem_writeData_o      = writeData_i;
      mem_dataMemControl_o = state == FILL ? 3'b010 : dataMemControl_i;
      mem_writeEnable_o    = state == IDLE && writeEnable_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         valid       <= '0;
         hitCount_o  <= '0;
         missCount_o <= '0;
         cnt         <= '0;
         fill_word   <= '0;
      end else if (state == FILL) begin
         if (cnt == '0) begin
            valid[fill_idx] <= 1'b1;
            state           <= IDLE;
         end else
            cnt <= cnt - 1'b1;
      end else if (writeEnable_i) begin
         if (match)
            valid[idx] <= 1'b0;
      end else if (readEnable_i) begin
         if (match)
            hitCount_o <= hitCount_o + 32'd1;
         else begin
            missCount_o <= missCount_o + 32'd1;
            fill_word   <= address_i[ADDRESS_WIDTH-1:2];
            cnt         <= CW'(MEM_LATENCY - 1);
            state       <= FILL;
         end
      end
   end

   // data and tag arrays need no reset; valid bits guard them
   always_ff @(posedge clk_i) begin
      if (!rst_i && state == FILL && cnt == '0) begin
         tags[fill_idx]  <= fill_word[ADDRESS_WIDTH-3:IW];
         words[fill_idx] <= mem_readData_i;
      end
   end
endmodule

// File: tb/tb_dcache_direct.sv
// tb_dcache_direct: scoreboard bench for dcache_direct with a word-addressed memory model.
module tb_dcache_direct;
   localparam int LAT = 3;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        readEnable_i;
   logic        writeEnable_i;
   logic [31:0] address_i;
   logic [31:0] writeData_i;
   logic [2:0]  dataMemControl_i;
   logic [31:0] readData_o;
   logic        stall_o;
   logic [31:0] mem_address_o;
   logic [31:0] mem_writeData_o;
   logic [2:0]  mem_dataMemControl_o;
   logic        mem_writeEnable_o;
   logic [31:0] mem_readData_i;
   logic [31:0] hitCount_o;
   logic [31:0] missCount_o;

   logic [31:0] mem_m [256];
   logic [31:0] exp_q [$];
   int checks = 0;
   int errors = 0;

   dcache_direct #(.MEM_LATENCY(LAT)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .readEnable_i(readEnable_i), .writeEnable_i(writeEnable_i),
      .address_i(address_i), .writeData_i(writeData_i), .dataMemControl_i(dataMemControl_i),
      .readData_o(readData_o), .stall_o(stall_o), .mem_address_o(mem_address_o),
      .mem_writeData_o(mem_writeData_o), .mem_dataMemControl_o(mem_dataMemControl_o),
      .mem_writeEnable_o(mem_writeEnable_o), .mem_readData_i(mem_readData_i),
      .hitCount_o(hitCount_o), .missCount_o(missCount_o)
   );

   always #5 clk_i = ~clk_i;
   assign mem_readData_i = mem_m[mem_address_o[9:2]];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] o, input logic [2:0] f);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{o, 3'b000} +: 8];
      h = o[1] ? w[31:16] : w[15:0];
      case (f)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'h0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'h0, h};
         default: return w;
      endcase
   endfunction

   task automatic load(input logic [31:0] a, input logic [2:0] f, input bit miss);
      int n = 0;
      address_i = a;
      dataMemControl_i = f;
      writeEnable_i = 1'b0;
      readEnable_i = 1'b1;
      exp_q.push_back(ext(mem_m[a[9:2]], a[1:0], f));
      @(negedge clk_i);
      while (stall_o && n < 20) begin
         if (n == 1) begin
            chk("fill_addr", mem_address_o, {a[31:2], 2'b00});
            chk("fill_ctl", 32'(mem_dataMemControl_o), 32'h2);
            chk("fill_we", 32'(mem_writeEnable_o), 32'h0);
         end
         n++;
         @(negedge clk_i);
      end
      chk("stall_cycles", 32'(n), miss ? 32'(LAT + 1) : 32'h0);
      chk("rdata", readData_o, exp_q.pop_front());
      @(posedge clk_i);
      #1 readEnable_i = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input bit both);
      address_i = a;
      writeData_i = d;
      dataMemControl_i = 3'b010;
      writeEnable_i = 1'b1;
      readEnable_i = both;
      @(negedge clk_i);
      chk("st_we", 32'(mem_writeEnable_o), 32'h1);
      chk("st_addr", mem_address_o, a);
      chk("st_data", mem_writeData_o, d);
      chk("st_stall", 32'(stall_o), 32'h0);
      chk("st_rdata", readData_o, 32'h0);
      mem_m[a[9:2]] = d;
      @(posedge clk_i);
      #1 writeEnable_i = 1'b0;
      readEnable_i = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
      mem_m[4]  = 32'h8000_00FF;
      mem_m[12] = 32'hCAFE_0001;
      rst_i = 1'b1;
      readEnable_i = 1'b0;
      writeEnable_i = 1'b0;
      address_i = 32'h0;
      writeData_i = 32'h0;
      dataMemControl_i = 3'b010;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_stall", 32'(stall_o), 32'h0);
      chk("rst_rdata", readData_o, 32'h0);
      chk("rst_we", 32'(mem_writeEnable_o), 32'h0);
      chk("rst_hits", hitCount_o, 32'h0);
      chk("rst_miss", missCount_o, 32'h0);
      @(posedge clk_i);
      #1;

      load(32'h10, 3'b010, 1'b1);
      chk("t1_miss", missCount_o, 32'd1);
      chk("t1_hits", hitCount_o, 32'd1);

      load(32'h10, 3'b000, 1'b0);
      load(32'h10, 3'b100, 1'b0);
      load(32'h12, 3'b001, 1'b0);
      load(32'h12, 3'b101, 1'b0);
      load(32'h13, 3'b010, 1'b0);
      load(32'h11, 3'b111, 1'b0);
      chk("t2_hits", hitCount_o, 32'd7);

      address_i = 32'h44;
      @(negedge clk_i);
      chk("idle_rdata", readData_o, 32'h0);
      chk("idle_addr", mem_address_o, 32'h44);
      chk("idle_we", 32'(mem_writeEnable_o), 32'h0);
      @(posedge clk_i);
      #1;

      store(32'h10, 32'h1234_5678, 1'b0);
      load(32'h10, 3'b010, 1'b1);
      chk("t3_miss", missCount_o, 32'd2);

      load(32'h30, 3'b010, 1'b1);
      load(32'h10, 3'b010, 1'b1);
      chk("t4_miss", missCount_o, 32'd4);
      chk("t4_hits", hitCount_o, 32'd10);

      store(32'h10, 32'hA5A5_A5A5, 1'b1);
      chk("t6_hits", hitCount_o, 32'd10);
      chk("t6_miss", missCount_o, 32'd4);
      load(32'h10, 3'b010, 1'b1);

      address_i = 32'h30;
      dataMemControl_i = 3'b010;
      readEnable_i = 1'b1;
      @(negedge clk_i);
      chk("t5_stall0", 32'(stall_o), 32'h1);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b1;
      readEnable_i = 1'b0;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("t5_stall", 32'(stall_o), 32'h0);
      chk("t5_hits", hitCount_o, 32'h0);
      chk("t5_miss", missCount_o, 32'h0);
      @(posedge clk_i);
      #1;
      load(32'h10, 3'b010, 1'b1);
      chk("t5_remiss", missCount_o, 32'd1);
      chk("t5_rehit", hitCount_o, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
